bool_encoder_lanes: RTL and testbench
=====================================

Name: bool_encoder_lanes

Overview:
Parametrised successor of the fixed 3-lane boolean path in the arithmetic encoder. It encodes up to NUM_LANES boolean symbols per accepted beat through a chained range/low/cnt update with per-lane renormalisation and word emission. It adds a valid/ready handshake with backpressure and a per-beat active-lane count, neither of which the 3-lane path has. It sits between the symbol front-end and the existing carry-resolution/bitstream packer.

Parameters:
NUM_LANES, 4, booleans encodable per beat (1..8)
RANGE_WIDTH, 16, range and output word width
LOW_WIDTH, 24, low register width
D_SIZE, 5, signed cnt width (two's complement)
PROB_WIDTH, 16, Q15 probability width per lane
CNT_W, $clog2(NUM_LANES+1), active-lane count width (derived)

Ports:
general_clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  beat offered
in_ready  out  1  beat accepted when in_valid&&in_ready
in_count  in  CNT_W  active lanes 0..NUM_LANES, lanes [0,in_count) used in order 0 first
in_bits  in  NUM_LANES  bit value per lane
in_probs  in  NUM_LANES*PROB_WIDTH  Q15 f per lane, lane i at [i*16 +: 16]
out_valid  out  1  result beat held
out_ready  in  1  downstream accepts
out_flags  out  2*NUM_LANES  per lane: 00 none, 01 word_1 valid, 10 word_1 then word_2 valid
out_words  out  2*NUM_LANES*RANGE_WIDTH  lane i word_1 at [(2i)*16 +: 16], word_2 at [(2i+1)*16 +: 16]
range_out  out  RANGE_WIDTH  committed range
low_out  out  LOW_WIDTH  committed low
cnt_out  out  D_SIZE  committed cnt (signed)

Behaviour:
- Reset (sync, active-high; overrides everything including a mid-stall beat): range=32768, low=0, cnt=-9, out_valid=0, out_flags=0, out_words=0.
- in_ready = !out_valid || out_ready (combinational).
- Accept with in_count>0: all lanes evaluated combinationally, chained in one cycle. Next cycle: range/low/cnt committed, out_valid=1, out_flags/out_words hold the beat's results. Latency 1.
- Accept with in_count=0: no state change; out_valid drops next cycle if out_ready consumed the current beat.
- Stall (out_valid&&!out_ready): all outputs and state held; no accept.
- Simultaneous consume and accept: new beat replaces old at the same edge, so throughput is 1 beat/cycle.
- Lanes >= in_count: flags=00, words=0, no state effect.
- Per-lane step (r,l,c in -> out), integer arithmetic:
  v = (((r>>8) * (f>>6)) >> 1) + 4, 18-bit product.
  bit=1: l += r - v; r = v. bit=0: r = r - v.
  d = 15 - msb_index(r); s = c + d.
  If s >= 0: c' = c+16, m = 2^c'-1. If s >= 8, emit word l>>c', l &= m, c' -= 8, m >>= 8. Then emit word l>>c', l &= m, s = c'+d-24.
  Result: l = l<<d truncated to LOW_WIDTH, r = r<<d, c = s.
- Emitted words are 16-bit and may carry above bit 7; carry is resolved downstream. After each step range is in [32768,65535].

Decomposition:
- Package bool_enc_pkg: EC_PROB_SHIFT=6, EC_MIN_PROB=4, CNT_INIT=-9, RANGE_INIT=32768, flag encodings FLAG_NONE/FLAG_ONE/FLAG_TWO.
- Sub-module bool_lane_step: combinational single-lane update and renormalisation. Instantiated NUM_LANES times and chained; each lane is bypassed when inactive.

Test Plan:
1. Reset -> range_out=32768, low_out=0, cnt_out=-9, out_valid=0, in_ready=1.
2. count=1, bit=0, f=16384 -> next cycle range=65520, low=0, cnt=-7, flags lane0=00, out_valid=1.
3. count=1, bit=1, f=16384 from reset -> range=32776, low=32760, cnt=-8, flags=00.
4. count=2, bits=1,1, f=0,0 from reset -> lane0 flags=01, word_1=255; lane1 flags=10, words 255,255. Final range=32768, low=98304, cnt=-7; lanes 2,3 flags=00.
5. out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs/state frozen. out_ready=1 -> pending input accepted the same edge, next result appears the following cycle.
6. Reset asserted while stalled -> all outputs return to reset values next cycle. Also: in_count=0 beat -> no state change, no out_valid.

Source files
------------

// File: rtl/bool_enc_pkg.sv
// bool_enc_pkg: shared constants for the boolean lane encoder
package bool_enc_pkg;
  localparam int EC_PROB_SHIFT = 6;
  localparam int EC_MIN_PROB = 4;
  localparam int CNT_INIT = -9;
  localparam int RANGE_INIT = 32768;
  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_ONE = 2'b01;
  localparam logic [1:0] FLAG_TWO = 2'b10;
endpackage

// File: rtl/bool_lane_step.sv
// bool_lane_step: single boolean symbol range/low/cnt update with renormalisation and word emission
module bool_lane_step
  import bool_enc_pkg::*;
#(
  parameter int RANGE_WIDTH = 16,
  parameter int LOW_WIDTH = 24,
  parameter int D_SIZE = 5,
  parameter int PROB_WIDTH = 16
) (
  input logic active,
  input logic bit_val,
  input logic [PROB_WIDTH-1:0] prob,
  input logic [RANGE_WIDTH-1:0] r,
  input logic [LOW_WIDTH-1:0] l,
  input logic signed [D_SIZE-1:0] c,
  output logic [RANGE_WIDTH-1:0] next_r,
  output logic [LOW_WIDTH-1:0] next_l,
  output logic signed [D_SIZE-1:0] next_c,
  output logic [1:0] flag,
  output logic [RANGE_WIDTH-1:0] word_1,
  output logic [RANGE_WIDTH-1:0] word_2
);
  localparam int XW = LOW_WIDTH + RANGE_WIDTH + 1;
  logic [17:0] prod;
  logic [RANGE_WIDTH-1:0] v, r1;
  logic [XW-1:0] l1, la, lb, lo;
  logic [4:0] d;
  logic signed [6:0] s, cp, c2, cn;
  logic emit, two;
  always_comb begin
    prod = 18'(r[RANGE_WIDTH-1 -: 8]) * 18'(prob >> EC_PROB_SHIFT);
    v = RANGE_WIDTH'(prod >> 1) + RANGE_WIDTH'(EC_MIN_PROB);
    r1 = bit_val ? v : r - v;
    l1 = XW'(l) + (bit_val ? XW'(r - v) : '0);
    d = '0;
    for (int i = 0; i < RANGE_WIDTH; i++) if (r1[i]) d = 5'(RANGE_WIDTH - 1 - i);
    s = 7'(c) + 7'(d);
    emit = !s[6];
    two = emit && s > 7'sd7;
    cp = 7'(c) + 7'sd16;
    c2 = two ? cp - 7'sd8 : cp;
    la = two ? l1 & ((XW'(1) << cp) - XW'(1)) : l1;
    lb = la & ((XW'(1) << c2) - XW'(1));
    cn = emit ? c2 + 7'(d) - 7'sd24 : s;
    lo = emit ? lb : l1;
    word_1 = active && emit ? RANGE_WIDTH'(l1 >> cp) : '0;
    word_2 = active && two ? RANGE_WIDTH'(la >> c2) : '0;
    flag = !active || !emit ? FLAG_NONE : two ? FLAG_TWO : FLAG_ONE;
    next_r = active ? r1 << d : r;
    next_l = active ? LOW_WIDTH'(lo << d) : l;
    next_c = active ? D_SIZE'(cn) : c;
  end
endmodule

// File: rtl/bool_encoder_lanes.sv
// bool_encoder_lanes: multi-lane chained boolean arithmetic encoder with valid/ready handshake
module bool_encoder_lanes
  import bool_enc_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int RANGE_WIDTH = 16,
  parameter int LOW_WIDTH = 24,
  parameter int D_SIZE = 5,
  parameter int PROB_WIDTH = 16,
  parameter int CNT_W = $clog2(NUM_LANES + 1)
) (
  input logic general_clk,
  input logic reset,
  input logic in_valid,
  output logic in_ready,
  input logic [CNT_W-1:0] in_count,
  input logic [NUM_LANES-1:0] in_bits,
  input logic [NUM_LANES*PROB_WIDTH-1:0] in_probs,
  output logic out_valid,
  input logic out_ready,
  output logic [2*NUM_LANES-1:0] out_flags,
  output logic [2*NUM_LANES*RANGE_WIDTH-1:0] out_words,
  output logic [RANGE_WIDTH-1:0] range_out,
  output logic [LOW_WIDTH-1:0] low_out,
  output logic signed [D_SIZE-1:0] cnt_out
);
  logic [RANGE_WIDTH-1:0] rc [NUM_LANES+1];
  logic [LOW_WIDTH-1:0] lc [NUM_LANES+1];
  logic signed [D_SIZE-1:0] cc [NUM_LANES+1];
  logic [2*NUM_LANES-1:0] flags;
  logic [2*NUM_LANES*RANGE_WIDTH-1:0] words;
  logic acc;
  assign rc[0] = range_out;
  assign lc[0] = low_out;
  assign cc[0] = cnt_out;
  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready && in_count != '0;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    bool_lane_step #(
      .RANGE_WIDTH(RANGE_WIDTH),
      .LOW_WIDTH(LOW_WIDTH),
      .D_SIZE(D_SIZE),
      .PROB_WIDTH(PROB_WIDTH)
    ) u_lane (
      .active(CNT_W'(i) < in_count),
      .bit_val(in_bits[i]),
      .prob(in_probs[i*PROB_WIDTH +: PROB_WIDTH]),
      .r(rc[i]),
      .l(lc[i]),
      .c(cc[i]),
      .next_r(rc[i+1]),
      .next_l(lc[i+1]),
      .next_c(cc[i+1]),
      .flag(flags[2*i +: 2]),
      .word_1(words[2*i*RANGE_WIDTH +: RANGE_WIDTH]),
      .word_2(words[(2*i+1)*RANGE_WIDTH +: RANGE_WIDTH])
    );
  end
  always_ff @(posedge general_clk) begin
    if (reset) begin
      range_out <= RANGE_WIDTH'(RANGE_INIT);
      low_out <= '0;
      cnt_out <= D_SIZE'(CNT_INIT);
      out_valid <= 1'b0;
      out_flags <= '0;
      out_words <= '0;
    end else if (acc) begin
      range_out <= rc[NUM_LANES];
      low_out <= lc[NUM_LANES];
      cnt_out <= cc[NUM_LANES];
      out_valid <= 1'b1;
      out_flags <= flags;
      out_words <= words;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bool_encoder_lanes.sv
// tb_bool_encoder_lanes: randomized and directed self-checking bench against an arithmetic reference model
module tb_bool_encoder_lanes;
  localparam int NL = 4;
  localparam int RW = 16;
  localparam int LW = 24;
  localparam int DS = 5;
  localparam int PW = 16;
  localparam int CW = $clog2(NL + 1);
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [CW-1:0] in_count = '0;
  logic [NL-1:0] in_bits = '0;
  logic [NL*PW-1:0] in_probs = '0;
  logic [2*NL-1:0] out_flags;
  logic [2*NL*RW-1:0] out_words;
  logic [RW-1:0] range_out;
  logic [LW-1:0] low_out;
  logic signed [DS-1:0] cnt_out;
  int n = 0;
  int fails = 0;
  longint m_r, m_l;
  int m_c;
  logic m_valid;
  logic [2*NL-1:0] m_flags;
  logic [2*NL*RW-1:0] m_words;
  always #5 clk = ~clk;
  bool_encoder_lanes #(
    .NUM_LANES(NL),
    .RANGE_WIDTH(RW),
    .LOW_WIDTH(LW),
    .D_SIZE(DS),
    .PROB_WIDTH(PW)
  ) dut (
    .general_clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_count(in_count),
    .in_bits(in_bits),
    .in_probs(in_probs),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_flags(out_flags),
    .out_words(out_words),
    .range_out(range_out),
    .low_out(low_out),
    .cnt_out(cnt_out)
  );
  function automatic void lane_model(input bit b, input longint f, inout longint r, inout longint l, inout int c,
                                     output logic [1:0] fl, output logic [15:0] w1, output logic [15:0] w2);
    longint v, m;
    int d, s, cp;
    v = (((r >> 8) * (f >> 6)) >> 1) + 4;
    if (b) begin
      l = l + r - v;
      r = v;
    end else r = r - v;
    d = 0;
    while (d < 16 && (r << d) < 32768) d++;
    s = c + d;
    fl = 2'b00;
    w1 = '0;
    w2 = '0;
    if (s >= 0) begin
      cp = c + 16;
      m = (64'd1 << cp) - 1;
      if (s >= 8) begin
        w1 = 16'(l >> cp);
        l = l & m;
        cp -= 8;
        m = m >> 8;
        fl = 2'b10;
        w2 = 16'(l >> cp);
      end else begin
        fl = 2'b01;
        w1 = 16'(l >> cp);
      end
      l = l & m;
      s = cp + d - 24;
    end
    l = (l << d) & 64'hFFFFFF;
    r = r << d;
    c = s;
  endfunction
  function automatic void model_beat();
    logic [1:0] fl;
    logic [15:0] w1, w2;
    m_flags = '0;
    m_words = '0;
    for (int i = 0; i < NL; i++) if (i < int'(in_count)) begin
      lane_model(in_bits[i], longint'(in_probs[i*PW +: PW]), m_r, m_l, m_c, fl, w1, w2);
      m_flags[2*i +: 2] = fl;
      m_words[2*i*RW +: RW] = w1;
      m_words[(2*i+1)*RW +: RW] = w2;
    end
  endfunction
  task automatic tick();
    if (reset) begin
      m_r = 32768;
      m_l = 0;
      m_c = -9;
      m_valid = 1'b0;
      m_flags = '0;
      m_words = '0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      if (in_count != '0) begin
        model_beat();
        m_valid = 1'b1;
      end else m_valid = 1'b0;
    end else if (out_ready) m_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic drive(input int cnt, input logic [NL-1:0] b, input logic [NL*PW-1:0] p);
    in_valid = 1'b1;
    in_count = CW'(cnt);
    in_bits = b;
    in_probs = p;
  endtask
  task automatic test_reset();
    do_reset();
    tick();
    n++;
    if (range_out !== 16'd32768) begin fails++; $display("FAIL reset_range got %0d want 32768", range_out); end
    n++;
    if (low_out !== 24'd0) begin fails++; $display("FAIL reset_low got %0d want 0", low_out); end
    n++;
    if (cnt_out !== -5'sd9) begin fails++; $display("FAIL reset_cnt got %0d want -9", $signed(cnt_out)); end
    n++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_handshake got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
  endtask
  task automatic test_single_zero();
    do_reset();
    drive(1, 4'b0000, {4{16'd16384}});
    tick();
    in_valid = 1'b0;
    n++;
    if ({out_valid, range_out, low_out, cnt_out, out_flags} !== {1'b1, 16'd65520, 24'd0, -5'sd7, 8'h00}) begin
      fails++; $display("FAIL single_zero got v=%b r=%0d l=%0d c=%0d f=%h want v=1 r=65520 l=0 c=-7 f=00",
                        out_valid, range_out, low_out, $signed(cnt_out), out_flags);
    end
  endtask
  task automatic test_single_one();
    do_reset();
    drive(1, 4'b0001, {4{16'd16384}});
    tick();
    in_valid = 1'b0;
    n++;
    if ({out_valid, range_out, low_out, cnt_out, out_flags} !== {1'b1, 16'd32776, 24'd32760, -5'sd8, 8'h00}) begin
      fails++; $display("FAIL single_one got v=%b r=%0d l=%0d c=%0d f=%h want v=1 r=32776 l=32760 c=-8 f=00",
                        out_valid, range_out, low_out, $signed(cnt_out), out_flags);
    end
  endtask
  task automatic test_two_lanes();
    do_reset();
    drive(2, 4'b0011, '0);
    tick();
    in_valid = 1'b0;
    n++;
    if (out_flags !== 8'b0000_1001) begin fails++; $display("FAIL two_lanes_flags got %b want 00001001", out_flags); end
    n++;
    if (out_words !== {64'd0, 16'd255, 16'd255, 16'd0, 16'd255}) begin
      fails++; $display("FAIL two_lanes_words got %h want %h", out_words, {64'd0, 16'd255, 16'd255, 16'd0, 16'd255});
    end
    n++;
    if ({range_out, low_out, cnt_out} !== {16'd32768, 24'd98304, -5'sd7}) begin
      fails++; $display("FAIL two_lanes_state got r=%0d l=%0d c=%0d want r=32768 l=98304 c=-7",
                        range_out, low_out, $signed(cnt_out));
    end
  endtask
  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    drive(1, 4'b0000, {4{16'd16384}});
    tick();
    drive(3, 4'b0101, {16'd9000, 16'd300, 16'd20000, 16'd1000});
    for (int k = 0; k < 3; k++) begin
      tick();
      n++;
      if ({in_ready, out_valid, range_out, low_out, cnt_out, out_flags} !== {1'b0, 1'b1, 16'd65520, 24'd0, -5'sd7, 8'h00}) begin
        fails++; $display("FAIL stall_hold cycle %0d got rdy=%b v=%b r=%0d l=%0d c=%0d want rdy=0 v=1 r=65520 l=0 c=-7",
                          k, in_ready, out_valid, range_out, low_out, $signed(cnt_out));
      end
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n++;
    if ({out_valid, range_out, low_out, cnt_out, out_flags, out_words} !== {1'b1, 16'(m_r), 24'(m_l), 5'(m_c), m_flags, m_words}
        || range_out === 16'd65520) begin
      fails++; $display("FAIL stall_release got v=%b r=%0d l=%0d c=%0d f=%h want v=1 r=%0d l=%0d c=%0d f=%h",
                        out_valid, range_out, low_out, $signed(cnt_out), out_flags, m_r, m_l, m_c, m_flags);
    end
    tick();
    n++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_drain got valid=%b want 0", out_valid); end
  endtask
  task automatic test_reset_stall();
    do_reset();
    out_ready = 1'b0;
    drive(2, 4'b0010, {4{16'd12345}});
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    n++;
    if ({out_valid, range_out, low_out, cnt_out, out_flags, out_words} !== {1'b0, 16'd32768, 24'd0, -5'sd9, 8'h00, 128'd0}) begin
      fails++; $display("FAIL reset_stall got v=%b r=%0d l=%0d c=%0d f=%h w=%h want v=0 r=32768 l=0 c=-9 f=00 w=0",
                        out_valid, range_out, low_out, $signed(cnt_out), out_flags, out_words);
    end
    out_ready = 1'b1;
  endtask
  task automatic test_zero_count();
    do_reset();
    drive(1, 4'b0000, {4{16'd16384}});
    tick();
    drive(0, 4'b1111, {4{16'd777}});
    tick();
    n++;
    if ({out_valid, range_out, low_out, cnt_out} !== {1'b0, 16'd65520, 24'd0, -5'sd7}) begin
      fails++; $display("FAIL zero_count got v=%b r=%0d l=%0d c=%0d want v=0 r=65520 l=0 c=-7",
                        out_valid, range_out, low_out, $signed(cnt_out));
    end
    in_valid = 1'b0;
  endtask
  task automatic test_random();
    logic [NL*PW-1:0] p;
    do_reset();
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < NL; i++) p[i*PW +: PW] = PW'($urandom_range(0, 32767));
      drive($urandom_range(0, NL), NL'($urandom), p);
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      tick();
      n++;
      if ({out_valid, range_out, low_out, cnt_out, out_flags, out_words, in_ready} !==
          {m_valid, 16'(m_r), 24'(m_l), 5'(m_c), m_flags, m_words, !m_valid || out_ready}) begin
        fails++; $display("FAIL random beat %0d got v=%b r=%0d l=%0d c=%0d f=%h w=%h want v=%b r=%0d l=%0d c=%0d f=%h w=%h",
                          k, out_valid, range_out, low_out, $signed(cnt_out), out_flags, out_words,
                          m_valid, m_r, m_l, m_c, m_flags, m_words);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask
  initial begin
    test_reset();
    test_single_zero();
    test_single_one();
    test_two_lanes();
    test_stall();
    test_reset_stall();
    test_zero_count();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
